// File: rtl/mdu_ctrl.sv
// Iterative 32-bit multiply/divide unit: shift-add multiply, restoring divide,
// one iteration per clock, with a handshake on both the request and result sides.
module mdu_ctrl (
   input  logic        clock,
   input  logic        reset,
   input  logic        valid_i,
   output logic        ready_o,
   input  logic [2:0]  op_i,
   input  logic [31:0] src1_i,
   input  logic [31:0] src2_i,
   input  logic [4:0]  waddr_i,
   input  logic        flush_i,
   output logic        valid_o,
   input  logic        ready_i,
   output logic [31:0] result_o,
   output logic [4:0]  waddr_o
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [2:0] OP_MUL   = 3'd0;
   localparam logic [2:0] OP_MULH  = 3'd1;
   localparam logic [2:0] OP_MULHU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_REM   = 3'd5;
   localparam logic [2:0] OP_REMU  = 3'd6;
   localparam logic [2:0] OP_RSV   = 3'd7;

   state_t      state, next_state;
   logic [5:0]  count;
   logic [2:0]  op_r;
   logic [4:0]  waddr_r;
   logic        neg_r;
   logic [63:0] mcand;
   logic [31:0] mplier;
   logic [63:0] acc;
   logic [31:0] res_r;

   logic        accept, is_div_in, signed_in, special, neg_in;
   logic [31:0] mag1, mag2, special_res;
   logic [63:0] step_acc, step_mcand, prod;
   logic [31:0] step_mplier, final_res;
   logic [32:0] shifted, diff;

   // Request decode: operand magnitudes, sign of the final result, and the
   // corner cases that finish without iterating.
   always_comb begin
      accept      = (state == IDLE) && valid_i && !flush_i;
      is_div_in   = (op_i == OP_DIV) || (op_i == OP_DIVU) || (op_i == OP_REM) || (op_i == OP_REMU);
      signed_in   = (op_i == OP_MUL) || (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
      mag1        = (signed_in && src1_i[31]) ? -src1_i : src1_i;
      mag2        = (signed_in && src2_i[31]) ? -src2_i : src2_i;
      neg_in      = (op_i == OP_REM) ? src1_i[31] : (signed_in && (src1_i[31] ^ src2_i[31]));
      special     = 1'b0;
      special_res = 32'd0;
      if (op_i == OP_RSV) begin
         special = 1'b1;
      end else if (is_div_in && (src2_i == 32'd0)) begin
         special     = 1'b1;
         special_res = ((op_i == OP_DIV) || (op_i == OP_DIVU)) ? 32'hFFFF_FFFF : src1_i;
      end else if (((op_i == OP_DIV) || (op_i == OP_REM)) &&
                   (src1_i == 32'h8000_0000) && (src2_i == 32'hFFFF_FFFF)) begin
         special     = 1'b1;
         special_res = (op_i == OP_DIV) ? 32'h8000_0000 : 32'd0;
      end
   end

   // One iteration step; the divider keeps its remainder in acc[31:0], the
   // divisor in mcand[31:0] and grows the quotient in mplier.
   always_comb begin
      shifted     = {acc[31:0], mplier[31]};
      diff        = shifted - {1'b0, mcand[31:0]};
      step_acc    = acc;
      step_mcand  = mcand;
      step_mplier = mplier;
      if (op_r <= OP_MULHU) begin
         step_acc    = acc + (mplier[0] ? mcand : 64'd0);
         step_mcand  = {mcand[62:0], 1'b0};
         step_mplier = {1'b0, mplier[31:1]};
      end else begin
         step_acc    = {32'd0, diff[32] ? shifted[31:0] : diff[31:0]};
         step_mplier = {mplier[30:0], ~diff[32]};
      end
      prod = neg_r ? -step_acc : step_acc;
      case (op_r)
         OP_MUL:            final_res = prod[31:0];
         OP_MULH, OP_MULHU: final_res = prod[63:32];
         OP_DIV, OP_DIVU:   final_res = neg_r ? -step_mplier : step_mplier;
         OP_REM, OP_REMU:   final_res = neg_r ? -step_acc[31:0] : step_acc[31:0];
         default:           final_res = 32'd0;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // Flush wins over both accepting a request and handing off a result.
   always_comb begin
      next_state = state;
      if (flush_i) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE:    if (valid_i) next_state = special ? DONE : BUSY;
            BUSY:    if (count == 6'd31) next_state = DONE;
            DONE:    if (ready_i) next_state = IDLE;
            default: next_state = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count   <= 6'd0;
         op_r    <= 3'd0;
         waddr_r <= 5'd0;
         neg_r   <= 1'b0;
         mcand   <= 64'd0;
         mplier  <= 32'd0;
         acc     <= 64'd0;
         res_r   <= 32'd0;
      end else if (accept) begin
         count   <= 6'd0;
         op_r    <= op_i;
         waddr_r <= waddr_i;
         neg_r   <= neg_in;
         acc     <= 64'd0;
         mcand   <= {32'd0, is_div_in ? mag2 : mag1};
         mplier  <= is_div_in ? mag1 : mag2;
         res_r   <= special_res;
      end else if ((state == BUSY) && !flush_i) begin
         count  <= count + 6'd1;
         acc    <= step_acc;
         mcand  <= step_mcand;
         mplier <= step_mplier;
         if (count == 6'd31) res_r <= final_res;
      end
   end

   assign ready_o  = (state == IDLE) && !reset;
   assign valid_o  = (state == DONE);
   assign result_o = valid_o ? res_r : 32'd0;
   assign waddr_o  = valid_o ? waddr_r : 5'd0;

endmodule
